// File: rtl/input_buffer_pkg.sv
// Shared types and sizing helpers for the router input-port buffer.
package input_buffer_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 4;

    typedef logic [DEFAULT_WIDTH-1:0] flit_t;

    // Ceiling log2; returns at least 1 so that a DEPTH of 1 still gets a 1-bit field.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/input_buffer_ptr.sv
// Wrapping pointer register. Wrap-around relies on the natural overflow of a
// power-of-two pointer width.
module input_buffer_ptr
    import input_buffer_pkg::*;
#(
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/input_buffer_fifo.sv
// Router input-port buffer: first-word-fall-through FIFO with valid/ready on
// both sides and a one-cycle credit pulse returned upstream for every pop.
module input_buffer_fifo
    import input_buffer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic [WIDTH-1:0]             data_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [clog2(DEPTH+1)-1:0]    count_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         credit_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             credit;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign full_o      = (count == CNT_W'(DEPTH));
    assign empty_o     = (count == '0);
    // Ready depends on state only, so a full buffer never accepts even while popping.
    assign in_ready_o  = reset && !full_o;
    assign out_valid_o = !empty_o;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign count_o     = count;
    assign credit_o    = credit;
    assign data_o      = empty_o ? '0 : mem_q[rd_ptr];

    input_buffer_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    input_buffer_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    // Storage is deliberately unreset; data_o masks it while empty.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [WIDTH-1:0] entry;

        always_ff @(posedge clk) begin
            if (push && (wr_ptr == PTR_W'(i))) begin
                entry <= data_i;
            end
        end

        assign mem_q[i] = entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit <= 1'b0;
        end else begin
            credit <= pop;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            assert (count <= CNT_W'(DEPTH));
            assert (!(push && full_o));
            assert (!(pop && empty_o));
        end
    end

endmodule

// File: tb/tb_input_buffer_fifo.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed expectations and a randomized phase.
module tb_input_buffer_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] data_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] data_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [CNT_W-1:0] count_o;
    logic             full_o;
    logic             empty_o;
    logic             credit_o;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q[$];
    bit               credit_m = 1'b0;
    bit               run_cmp = 1'b0;

    input_buffer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_i      (data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data_o      (data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .credit_o    (credit_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of accepted flits.
    always @(posedge clk) begin
        bit p;
        bit w;
        if (!reset) begin
            q.delete();
            credit_m = 1'b0;
        end else begin
            p = out_ready_i && (q.size() > 0);
            w = in_valid_i && (q.size() < DEPTH);
            if (p) void'(q.pop_front());
            if (w) q.push_back(data_i);
            credit_m = p;
        end
    end

    always @(negedge reset) begin
        q.delete();
        credit_m = 1'b0;
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            check("cmp_data", 32'(data_o), (q.size() > 0) ? 32'(q[0]) : 32'h0);
            check("cmp_valid", 32'(out_valid_o), 32'(q.size() > 0));
            check("cmp_count", 32'(count_o), 32'(q.size()));
            check("cmp_full", 32'(full_o), 32'(q.size() == DEPTH));
            check("cmp_empty", 32'(empty_o), 32'(q.size() == 0));
            check("cmp_ready", 32'(in_ready_o), 32'(reset && (q.size() < DEPTH)));
            check("cmp_credit", 32'(credit_o), 32'(credit_m));
        end
    end

    task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r);
        in_valid_i  = v;
        data_i      = d;
        out_ready_i = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] fill_vals [4];
        fill_vals[0] = 16'h0011;
        fill_vals[1] = 16'h0022;
        fill_vals[2] = 16'h0033;
        fill_vals[3] = 16'h0044;

        reset = 1'b1;
        in_valid_i = 1'b0;
        data_i = '0;
        out_ready_i = 1'b0;
        #1 reset = 1'b0;
        #1;
        run_cmp = 1'b1;

        // Reset state
        check("rst_ready", 32'(in_ready_o), 32'h0);
        check("rst_valid", 32'(out_valid_o), 32'h0);
        check("rst_data", 32'(data_o), 32'h0);
        check("rst_count", 32'(count_o), 32'h0);
        check("rst_empty", 32'(empty_o), 32'h1);
        repeat (3) cyc(1'b0, '0, 1'b0);
        reset = 1'b1;
        cyc(1'b0, '0, 1'b0);
        check("rel_ready", 32'(in_ready_o), 32'h1);

        // Fill and drain
        for (int k = 0; k < 4; k++) cyc(1'b1, fill_vals[k], 1'b0);
        check("fill_count", 32'(count_o), 32'h4);
        check("fill_full", 32'(full_o), 32'h1);
        check("fill_ready", 32'(in_ready_o), 32'h0);
        cyc(1'b1, 16'h0055, 1'b0);
        check("fifth_count", 32'(count_o), 32'h4);
        for (int k = 0; k < 4; k++) begin
            check("drain_data", 32'(data_o), 32'(fill_vals[k]));
            cyc(1'b0, '0, 1'b1);
            check("drain_credit", 32'(credit_o), 32'h1);
        end
        check("drain_empty", 32'(empty_o), 32'h1);
        check("drain_data0", 32'(data_o), 32'h0);
        cyc(1'b0, '0, 1'b0);
        check("drain_credit_end", 32'(credit_o), 32'h0);

        // Wrap-around streaming
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b1, 16'(k), 1'b1);
            check("wrap_data", 32'(data_o), 32'(k));
            check("wrap_count", 32'(count_o), 32'h1);
        end
        cyc(1'b0, '0, 1'b1);
        check("wrap_empty", 32'(empty_o), 32'h1);

        // Full with simultaneous pop
        for (int k = 0; k < 4; k++) cyc(1'b1, 16'h0100 + 16'(k), 1'b0);
        in_valid_i = 1'b1;
        data_i = 16'h0200;
        out_ready_i = 1'b1;
        #1;
        check("fullpop_ready", 32'(in_ready_o), 32'h0);
        cyc(1'b1, 16'h0200, 1'b1);
        check("fullpop_count", 32'(count_o), 32'h3);
        check("fullpop_head", 32'(data_o), 32'h0101);
        cyc(1'b1, 16'h0200, 1'b0);
        check("fullpop_refill", 32'(count_o), 32'h4);

        // Async reset mid-stream
        cyc(1'b0, '0, 1'b1);
        check("mid_count3", 32'(count_o), 32'h3);
        out_ready_i = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_count", 32'(count_o), 32'h0);
        check("mid_valid", 32'(out_valid_o), 32'h0);
        check("mid_credit", 32'(credit_o), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        cyc(1'b1, 16'h00AB, 1'b0);
        check("mid_after_data", 32'(data_o), 32'h00AB);
        check("mid_after_valid", 32'(out_valid_o), 32'h1);

        // Pop requests while empty
        cyc(1'b0, '0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, '0, 1'b1);
            check("emptypop_credit", 32'(credit_o), 32'h0);
            check("emptypop_count", 32'(count_o), 32'h0);
        end

        // Randomized traffic with occasional async resets
        for (int n = 0; n < 3000; n++) begin
            cyc(1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFF)),
                1'($urandom_range(0, 2) != 0 ? ($urandom_range(0, 1)) : 0));
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b0;
                @(posedge clk);
                #1 reset = 1'b1;
            end
        end

        @(negedge clk);
        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
